// File: rtl/ddr4_seq_pkg.sv
// Shared types and pin-encoding constants for the DDR4 command sequencer.
// Refresh states are present only when DDR4_SEQ_REFRESH_EN is defined.
package ddr4_seq_pkg;

  localparam int TMR_W   = 16;
  localparam int RAS_BIT = 16;
  localparam int CAS_BIT = 15;
  localparam int WE_BIT  = 14;
  localparam int A10_BIT = 10;

  typedef enum logic [2:0] {
    CMD_DES,
    CMD_ACT,
    CMD_RD,
    CMD_WR,
    CMD_PRE,
    CMD_PREA,
    CMD_REF
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_PRE,
    S_ACT,
    S_RW
`ifdef DDR4_SEQ_REFRESH_EN
    ,
    S_REF_PREA,
    S_REF,
    S_REF_WAIT
`endif
  } state_t;

  function automatic logic [TMR_W-1:0] dec_sat(input logic [TMR_W-1:0] t);
    return (t == '0) ? t : t - TMR_W'(1);
  endfunction

endpackage

// File: rtl/ddr4_bank_table.sv
// Open-row tracker: one {open, row} entry per bank, combinational lookup,
// synchronous update on ACT/PRE (and PREA when DDR4_SEQ_REFRESH_EN is defined).
module ddr4_bank_table
  import ddr4_seq_pkg::*;
#(
  parameter int ADDRWIDTH = 17,
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BGWIDTH-1:0]   lk_bg,
  input  logic [BAWIDTH-1:0]   lk_ba,
  input  logic [ADDRWIDTH-1:0] lk_row,
  output logic                 lk_open,
  output logic                 lk_hit,
`ifdef DDR4_SEQ_REFRESH_EN
  output logic                 any_open,
  input  logic                 prea_en,
`endif
  input  logic                 act_en,
  input  logic                 pre_en,
  input  logic [BGWIDTH-1:0]   upd_bg,
  input  logic [BAWIDTH-1:0]   upd_ba,
  input  logic [ADDRWIDTH-1:0] upd_row
);

  localparam int IW = BGWIDTH + BAWIDTH;
  localparam int NB = 2 ** IW;

  logic [NB-1:0]        open_q;
  logic [ADDRWIDTH-1:0] row_q [NB];
  logic [IW-1:0]        lk_idx;
  logic [IW-1:0]        upd_idx;

  assign lk_idx  = {lk_bg, lk_ba};
  assign upd_idx = {upd_bg, upd_ba};
  assign lk_open = open_q[lk_idx];
  assign lk_hit  = open_q[lk_idx] && (row_q[lk_idx] == lk_row);

`ifdef DDR4_SEQ_REFRESH_EN
  assign any_open = |open_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      open_q <= '0;
    end else begin
      if (act_en) open_q[upd_idx] <= 1'b1;
      if (pre_en) open_q[upd_idx] <= 1'b0;
`ifdef DDR4_SEQ_REFRESH_EN
      if (prea_en) open_q <= '0;
`endif
    end
  end

  // NOTE: row storage has no reset; an entry is only trusted while its open bit is set.
  always_ff @(posedge clk) begin
    if (!rst && act_en) row_q[upd_idx] <= upd_row;
  end

endmodule

// File: rtl/ddr4_cmd_sequencer.sv
// Turns single read/write requests into DDR4 ACT/RD/WR/PRE pin sequences with an
// open-page policy. Define DDR4_SEQ_REFRESH_EN to add periodic PREA/REF refresh.
module ddr4_cmd_sequencer
  import ddr4_seq_pkg::*;
#(
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int TRCD      = 4,
  parameter int TRP       = 4,
  parameter int TCCD      = 4,
  parameter int TRFC      = 32,
  parameter int TREFI     = 1560
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [BGWIDTH-1:0]   req_bg,
  input  logic [BAWIDTH-1:0]   req_ba,
  input  logic [ADDRWIDTH-1:0] req_row,
  input  logic [COLWIDTH-1:0]  req_col,
  input  logic                 stall,
  output logic                 cke,
  output logic                 cs_n,
  output logic                 act_n,
  output logic [ADDRWIDTH-1:0] addr,
  output logic [BGWIDTH-1:0]   bg,
  output logic [BAWIDTH-1:0]   ba,
  output logic                 rd_issue,
  output logic                 wr_issue
);

  state_t               state;
  cmd_t                 cmd;
  logic                 write_q;
  logic [BGWIDTH-1:0]   bg_q;
  logic [BAWIDTH-1:0]   ba_q;
  logic [ADDRWIDTH-1:0] row_q;
  logic [COLWIDTH-1:0]  col_q;
  logic [TMR_W-1:0]     trcd_tmr, trp_tmr, tccd_tmr;
  logic                 lk_open, lk_hit;
  logic                 cs_n_d, act_n_d;
  logic [ADDRWIDTH-1:0] addr_d;
  logic [BGWIDTH-1:0]   bg_d;
  logic [BAWIDTH-1:0]   ba_d;

`ifdef DDR4_SEQ_REFRESH_EN
  logic [TMR_W-1:0]     trfc_tmr, refi_tmr;
  logic                 refresh_pending;
  logic                 any_open;
`endif

  ddr4_bank_table #(
    .ADDRWIDTH(ADDRWIDTH),
    .BGWIDTH  (BGWIDTH),
    .BAWIDTH  (BAWIDTH)
  ) u_bank_table (
    .clk     (clk),
    .rst     (rst),
    .lk_bg   (bg_q),
    .lk_ba   (ba_q),
    .lk_row  (row_q),
    .lk_open (lk_open),
    .lk_hit  (lk_hit),
`ifdef DDR4_SEQ_REFRESH_EN
    .any_open(any_open),
    .prea_en (cmd == CMD_PREA),
`endif
    .act_en  (cmd == CMD_ACT),
    .pre_en  (cmd == CMD_PRE),
    .upd_bg  (bg_q),
    .upd_ba  (ba_q),
    .upd_row (row_q)
  );

  // Command issued at the coming edge; the pins show it for the following cycle.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cmd = CMD_DES;
    if (!stall) begin
      case (state)
        S_PRE:      if (trcd_tmr == '0) cmd = CMD_PRE;
        S_ACT:      if (trp_tmr == '0) cmd = CMD_ACT;
        S_RW:       if (trcd_tmr == '0 && tccd_tmr == '0) cmd = write_q ? CMD_WR : CMD_RD;
`ifdef DDR4_SEQ_REFRESH_EN
        S_REF_PREA: if (trp_tmr == '0 && trcd_tmr == '0 && any_open) cmd = CMD_PREA;
        S_REF:      if (trp_tmr == '0) cmd = CMD_REF;
`endif
        default:    cmd = CMD_DES;
      endcase
    end
  end

  always_comb begin
    cs_n_d  = (cmd == CMD_DES);
    act_n_d = (cmd != CMD_ACT);
    addr_d  = '0;
    bg_d    = '0;
    ba_d    = '0;
    case (cmd)
      CMD_ACT: begin
        addr_d = row_q;
        bg_d   = bg_q;
        ba_d   = ba_q;
      end
      CMD_RD, CMD_WR: begin
        addr_d[COLWIDTH-1:0] = col_q;
        addr_d[RAS_BIT]      = 1'b1;
        addr_d[WE_BIT]       = (cmd == CMD_RD);
        bg_d                 = bg_q;
        ba_d                 = ba_q;
      end
      CMD_PRE: begin
        addr_d[CAS_BIT] = 1'b1;
        bg_d            = bg_q;
        ba_d            = ba_q;
      end
      CMD_PREA: begin
        addr_d[CAS_BIT] = 1'b1;
        addr_d[A10_BIT] = 1'b1;
      end
      CMD_REF:  addr_d[WE_BIT] = 1'b1;
      default:  ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; later assignments
  // in this block deliberately override the default timer countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      req_ready <= 1'b0;
      cke       <= 1'b0;
      cs_n      <= 1'b1;
      act_n     <= 1'b1;
      addr      <= '0;
      bg        <= '0;
      ba        <= '0;
      rd_issue  <= 1'b0;
      wr_issue  <= 1'b0;
      trcd_tmr  <= '0;
      trp_tmr   <= '0;
      tccd_tmr  <= '0;
      write_q   <= 1'b0;
      bg_q      <= '0;
      ba_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
`ifdef DDR4_SEQ_REFRESH_EN
      trfc_tmr        <= '0;
      refi_tmr        <= TMR_W'(TREFI - 1);
      refresh_pending <= 1'b0;
`endif
    end else begin
      cke      <= 1'b1;
      cs_n     <= cs_n_d;
      act_n    <= act_n_d;
      addr     <= addr_d;
      bg       <= bg_d;
      ba       <= ba_d;
      rd_issue <= (cmd == CMD_RD);
      wr_issue <= (cmd == CMD_WR);
      trcd_tmr <= dec_sat(trcd_tmr);
      trp_tmr  <= dec_sat(trp_tmr);
      tccd_tmr <= dec_sat(tccd_tmr);
`ifdef DDR4_SEQ_REFRESH_EN
      trfc_tmr <= dec_sat(trfc_tmr);
`endif

      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            write_q   <= req_write;
            bg_q      <= req_bg;
            ba_q      <= req_ba;
            row_q     <= req_row;
            col_q     <= req_col;
            req_ready <= 1'b0;
            state     <= S_LOOKUP;
          end
`ifdef DDR4_SEQ_REFRESH_EN
          else if (refresh_pending) begin
            req_ready <= 1'b0;
            state     <= S_REF_PREA;
          end
`endif
          else begin
            req_ready <= 1'b1;
          end
        end
        S_LOOKUP: state <= !lk_open ? S_ACT : (lk_hit ? S_RW : S_PRE);
        S_PRE: begin
          if (cmd == CMD_PRE) begin
            trp_tmr <= TMR_W'(TRP - 1);
            state   <= S_ACT;
          end
        end
        S_ACT: begin
          if (cmd == CMD_ACT) begin
            trcd_tmr <= TMR_W'(TRCD - 1);
            state    <= S_RW;
          end
        end
        S_RW: begin
          if (cmd == CMD_RD || cmd == CMD_WR) begin
            tccd_tmr  <= TMR_W'(TCCD - 1);
            state     <= S_IDLE;
`ifdef DDR4_SEQ_REFRESH_EN
            req_ready <= !refresh_pending;
`else
            req_ready <= 1'b1;
`endif
          end
        end
`ifdef DDR4_SEQ_REFRESH_EN
        // With every bank already closed the PREA is skipped and REF follows directly.
        S_REF_PREA: begin
          if (!stall && trp_tmr == '0 && trcd_tmr == '0) begin
            if (any_open) trp_tmr <= TMR_W'(TRP - 1);
            state <= S_REF;
          end
        end
        S_REF: begin
          if (cmd == CMD_REF) begin
            trfc_tmr <= TMR_W'(TRFC - 1);
            state    <= S_REF_WAIT;
          end
        end
        S_REF_WAIT: begin
          if (trfc_tmr == '0) begin
            refresh_pending <= 1'b0;
            req_ready       <= 1'b1;
            state           <= S_IDLE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase

`ifdef DDR4_SEQ_REFRESH_EN
      if (refi_tmr == '0) begin
        refi_tmr        <= TMR_W'(TREFI - 1);
        refresh_pending <= 1'b1;
      end else begin
        refi_tmr <= refi_tmr - TMR_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_ddr4_cmd_sequencer.sv
// Directed bench for ddr4_cmd_sequencer (default build): miss, hit, conflict,
// stall and mid-sequence reset, with pin events logged on the falling edge.
module tb_ddr4_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_bg = '0;
  logic [1:0]  req_ba = '0;
  logic [16:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic        stall = 1'b0;
  logic        cke, cs_n, act_n, rd_issue, wr_issue;
  logic [16:0] addr;
  logic [1:0]  bg, ba;

  ddr4_cmd_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_bg   (req_bg),
    .req_ba   (req_ba),
    .req_row  (req_row),
    .req_col  (req_col),
    .stall    (stall),
    .cke      (cke),
    .cs_n     (cs_n),
    .act_n    (act_n),
    .addr     (addr),
    .bg       (bg),
    .ba       (ba),
    .rd_issue (rd_issue),
    .wr_issue (wr_issue)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          at;
    logic        act_n;
    logic [16:0] addr;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic        rd;
    logic        wr;
    logic        rdy;
  } ev_t;

  ev_t cmd_log[$];
  int  edge_cnt = 0;
  int  n_rd = 0;
  int  n_wr = 0;
  int  n_orphan = 0;
  int  n_cmp = 0;
  int  n_fail = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    if (!cs_n) cmd_log.push_back('{edge_cnt, act_n, addr, bg, ba, rd_issue, wr_issue, req_ready});
    if (rd_issue) n_rd++;
    if (wr_issue) n_wr++;
    if ((rd_issue || wr_issue) && cs_n) n_orphan++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic ev_t get_ev(input int i);
    ev_t e;
    e = '{-1000, 1'b1, 17'h0, 2'b0, 2'b0, 1'b0, 1'b0, 1'b0};
    if (i < cmd_log.size()) e = cmd_log[i];
    return e;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic do_req(input logic w, input logic [1:0] g, input logic [1:0] b,
                        input logic [16:0] r, input logic [9:0] col, output int c);
    cmd_log.delete();
    req_valid = 1'b1;
    req_write = w;
    req_bg    = g;
    req_ba    = b;
    req_row   = r;
    req_col   = col;
    c = -1;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin
        @(posedge clk);
        @(negedge clk);
        c = edge_cnt;
        break;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("accepted", 32'(c != -1), 32'd1);
  endtask

  task automatic wait_cmds(input string tag, input int n);
    for (int i = 0; i < 40 && cmd_log.size() < n; i++) @(negedge clk);
    check({tag, ".count"}, 32'(cmd_log.size()), 32'(n));
  endtask

  task automatic exp_cmd(input string tag, input int idx, input int c, input int off,
                         input logic an, input logic [16:0] a, input logic [1:0] g,
                         input logic [1:0] b, input logic rd, input logic wr);
    ev_t e;
    e = get_ev(idx);
    check({tag, ".cycle"}, 32'(e.at - c), 32'(off));
    check({tag, ".act_n"}, 32'(e.act_n), 32'(an));
    check({tag, ".addr"},  32'(e.addr),  32'(a));
    check({tag, ".bg"},    32'(e.bg),    32'(g));
    check({tag, ".ba"},    32'(e.ba),    32'(b));
    check({tag, ".rd"},    32'(e.rd),    32'(rd));
    check({tag, ".wr"},    32'(e.wr),    32'(wr));
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, ".cke"},   32'(cke),   32'd0);
    check({tag, ".ready"}, 32'(req_ready), 32'd0);
    check({tag, ".pins"},  32'({cs_n, act_n, addr, bg, ba, rd_issue, wr_issue}),
          32'({1'b1, 1'b1, 17'h0, 2'b0, 2'b0, 1'b0, 1'b0}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, p;

    // Reset values, then cke/req_ready rise one edge after rst drops.
    repeat (3) @(negedge clk);
    check_reset_pins("reset");
    rst = 1'b0;
    @(negedge clk);
    check("post_reset.cke",   32'(cke), 32'd1);
    check("post_reset.ready", 32'(req_ready), 32'd1);

    // Miss: ACT at c+2, RD at c+6.
    do_req(1'b0, 2'd1, 2'd2, 17'h155, 10'h3A, c);
    wait_cmds("miss", 2);
    exp_cmd("miss.act", 0, c, 2, 1'b0, 17'h00155, 2'd1, 2'd2, 1'b0, 1'b0);
    exp_cmd("miss.rd",  1, c, 6, 1'b1, 17'h1403A, 2'd1, 2'd2, 1'b1, 1'b0);
    check("miss.rd_ready", 32'(get_ev(1).rdy), 32'd1);
    p = get_ev(1).at;

    // Hit right after: WR no earlier than previous RD + TCCD, no ACT.
    do_req(1'b1, 2'd1, 2'd2, 17'h155, 10'h10, c);
    wait_cmds("hit", 1);
    exp_cmd("hit.wr", 0, p, 4, 1'b1, 17'h10010, 2'd1, 2'd2, 1'b0, 1'b1);

    // Conflict: PRE at c+2, ACT at c+6, RD at c+10.
    do_req(1'b0, 2'd1, 2'd2, 17'h0AA, 10'h05, c);
    wait_cmds("conf", 3);
    exp_cmd("conf.pre", 0, c, 2,  1'b1, 17'h08000, 2'd1, 2'd2, 1'b0, 1'b0);
    exp_cmd("conf.act", 1, c, 6,  1'b0, 17'h000AA, 2'd1, 2'd2, 1'b0, 1'b0);
    exp_cmd("conf.rd",  2, c, 10, 1'b1, 17'h14005, 2'd1, 2'd2, 1'b1, 1'b0);

    // Stall sampled high at edges c+2..c+9 on a miss: ACT at c+10, RD at c+14.
    do_req(1'b0, 2'd0, 2'd0, 17'h00003, 10'h07, c);
    @(negedge clk);
    stall = 1'b1;
    repeat (8) @(negedge clk);
    check("stall.quiet", 32'(cmd_log.size()), 32'd0);
    stall = 1'b0;
    wait_cmds("stall", 2);
    exp_cmd("stall.act", 0, c, 10, 1'b0, 17'h00003, 2'd0, 2'd0, 1'b0, 1'b0);
    exp_cmd("stall.rd",  1, c, 14, 1'b1, 17'h14007, 2'd0, 2'd0, 1'b1, 1'b0);

    // Reset between ACT and RD: request dropped, bank table cleared.
    do_req(1'b0, 2'd3, 2'd1, 17'h1FF, 10'h02, c);
    wait_cmds("rst_mid", 1);
    exp_cmd("rst_mid.act", 0, c, 2, 1'b0, 17'h001FF, 2'd3, 2'd1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_pins("rst_mid");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_mid.no_rd", 32'(cmd_log.size()), 32'd1);
    check("rst_mid.ready", 32'(req_ready), 32'd1);
    do_req(1'b0, 2'd3, 2'd1, 17'h1FF, 10'h02, c);
    wait_cmds("after_rst", 2);
    exp_cmd("after_rst.act", 0, c, 2, 1'b0, 17'h001FF, 2'd3, 2'd1, 1'b0, 1'b0);
    exp_cmd("after_rst.rd",  1, c, 6, 1'b1, 17'h14002, 2'd3, 2'd1, 1'b1, 1'b0);

    repeat (4) @(negedge clk);
    check("total.rd_pulses", 32'(n_rd), 32'd4);
    check("total.wr_pulses", 32'(n_wr), 32'd1);
    check("total.orphan_pulses", 32'(n_orphan), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
